// File: rtl/irda_pkg.sv
// irda_pkg: shared constants, state type and helpers for the IrDA SIR transmitter.
package irda_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic {IDLE, SEND} tx_state_t;

    function automatic int frame_bits(int data_bits, int parity_mode, int stop_bits);
        return 1 + data_bits + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
    endfunction

    // Payload arrives zero-extended to 9 bits, which leaves the XOR unchanged.
    function automatic logic parity_of(logic [8:0] data, int mode);
        return (mode == PAR_ODD) ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/irda_bit_timer.sv
// irda_bit_timer: bit-period cycle counter giving the period wrap and the IR pulse window.
module irda_bit_timer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PULSE_CLKS   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic clear,
    output logic bit_end,
    output logic pulse_win
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt;

    assign bit_end   = cnt == CW'(CLKS_PER_BIT - 1);
    assign pulse_win = cnt < CW'(PULSE_CLKS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (ena)
            cnt <= bit_end ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/irda_tx_frame_gen.sv
// irda_tx_frame_gen: parametrised IrDA SIR transmitter with valid/ready input and RZI output.
module irda_tx_frame_gen
    import irda_pkg::*;
#(
    parameter int DATA_BITS    = 7,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int PULSE_CLKS   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 txd_ir,
    output logic                 busy,
    output logic                 done
);

    localparam int FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
    // A parity slot is always reserved; without parity it holds a 1 that reads as stop.
    localparam int SW = DATA_BITS + STOP_BITS + 2;
    localparam int IW = $clog2(FRAME_BITS);

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE < PAR_NONE || PARITY_MODE > PAR_ODD ||
            STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 4 ||
            PULSE_CLKS < 1 || PULSE_CLKS >= CLKS_PER_BIT) begin : g_bad_params
            $error("irda_tx_frame_gen: illegal parameter set");
        end
    endgenerate

    tx_state_t     state, state_nx;
    logic [SW-1:0] shreg, load;
    logic [IW-1:0] idx;
    logic          accept, step, last, bit_end, pulse_win;

    always_comb begin
        busy     = state == SEND;
        tx_ready = rst && ena && state == IDLE;
        accept   = tx_ready && tx_valid;
        step     = ena && busy && bit_end;
        last     = idx == IW'(FRAME_BITS - 1);
        state_nx = accept ? SEND : (step && last) ? IDLE : state;
    end

    always_comb begin
        load = {{(STOP_BITS + 1){1'b1}}, tx_data, 1'b0};
        if (PARITY_MODE != PAR_NONE)
            load[DATA_BITS+1] = parity_of(9'(tx_data), PARITY_MODE);
    end

    irda_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .PULSE_CLKS  (PULSE_CLKS)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .clear    (!busy),
        .bit_end  (bit_end),
        .pulse_win(pulse_win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            idx   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= step && last;
            if (accept) begin
                shreg <= load;
                idx   <= '0;
            end else if (step) begin
                shreg <= {1'b1, shreg[SW-1:1]};
                idx   <= idx + IW'(1);
            end
        end
    end

    // Built only from flops, so it is frozen whenever ena freezes the state.
    assign txd_ir = busy & ~shreg[0] & pulse_win;

endmodule

// File: tb/tb_irda_tx_frame_gen.sv
// tb_irda_tx_frame_gen: directed vectors over three parameter sets plus multi-cycle corner sequences.
module tb_irda_tx_frame_gen;

    localparam int CPB[3] = '{16, 16, 8};
    localparam int PW[3]  = '{3, 3, 2};
    localparam int FB[3]  = '{10, 10, 11};

    typedef struct {
        int          inst;
        logic [7:0]  data;
        logic [12:0] mask;
    } vec_t;

    logic       clk = 0, rst = 0, ena = 1;
    logic [2:0] v = '0;
    logic [7:0] d = '0;
    logic [2:0] rdy, ir, bsy, dn;
    int         cyc = 0, tests = 0, fails = 0;
    vec_t       vecs[8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    irda_tx_frame_gen u0 (
        .clk(clk), .rst(rst), .ena(ena), .tx_valid(v[0]), .tx_data(d[6:0]),
        .tx_ready(rdy[0]), .txd_ir(ir[0]), .busy(bsy[0]), .done(dn[0])
    );

    irda_tx_frame_gen #(.PARITY_MODE(2)) u1 (
        .clk(clk), .rst(rst), .ena(ena), .tx_valid(v[1]), .tx_data(d[6:0]),
        .tx_ready(rdy[1]), .txd_ir(ir[1]), .busy(bsy[1]), .done(dn[1])
    );

    irda_tx_frame_gen #(
        .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(8), .PULSE_CLKS(2)
    ) u2 (
        .clk(clk), .rst(rst), .ena(ena), .tx_valid(v[2]), .tx_data(d),
        .tx_ready(rdy[2]), .txd_ir(ir[2]), .busy(bsy[2]), .done(dn[2])
    );

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic wait_ready(int i);
        for (int n = 0; n < 400 && rdy[i] !== 1'b1; n++) @(negedge clk);
    endtask

    task automatic wait_done(int i);
        for (int n = 0; n < 400 && dn[i] !== 1'b1; n++) @(negedge clk);
    endtask

    // Drives one frame and samples every cycle of it, from acceptance+1 to the done cycle.
    task automatic run_frame(int i, logic [7:0] data, logic [12:0] mask, string name);
        logic [12:0] got_mask = '0;
        int          shape_err = 0, busy_cnt = 0;
        @(negedge clk);
        d    = data;
        v[i] = 1'b1;
        wait_ready(i);
        check({name, " ready"}, rdy[i], 1);
        @(negedge clk);
        v[i] = 1'b0;
        for (int k = 0; k < FB[i]; k++)
            for (int c = 0; c < CPB[i]; c++) begin
                if (c == 0) got_mask[k] = ir[i];
                if (ir[i] !== (mask[k] && c < PW[i])) shape_err++;
                if (dn[i] !== 1'b0) shape_err++;
                busy_cnt += int'(bsy[i]);
                @(negedge clk);
            end
        check({name, " pulse mask"}, got_mask, mask);
        check({name, " pulse shape errors"}, shape_err, 0);
        check({name, " busy cycles"}, busy_cnt, FB[i] * CPB[i]);
        check({name, " done at end"}, dn[i], 1);
        check({name, " idle after frame"}, bsy[i], 0);
    endtask

    initial begin
        int ta, ta2, hold_err, done_cnt;
        vecs[0] = '{0, 8'h55, 13'h155};
        vecs[1] = '{0, 8'h00, 13'h1FF};
        vecs[2] = '{0, 8'h7F, 13'h001};
        vecs[3] = '{0, 8'h01, 13'h0FD};
        vecs[4] = '{0, 8'h40, 13'h07F};
        vecs[5] = '{1, 8'h00, 13'h0FF};
        vecs[6] = '{1, 8'h03, 13'h0F9};
        vecs[7] = '{2, 8'hFF, 13'h001};

        repeat (2) @(negedge clk);
        check("reset txd_ir", ir, 0);
        check("reset tx_ready", rdy, 0);
        check("reset busy", bsy, 0);
        check("reset done", dn, 0);
        rst = 1'b1;
        @(negedge clk);
        check("ready after reset", rdy, 3'b111);

        foreach (vecs[j])
            run_frame(vecs[j].inst, vecs[j].data, vecs[j].mask, $sformatf("vec%0d", j));
        run_frame(2, 8'hA5, 13'h0B5, "cfg2 A5");

        // Back-to-back: tx_valid held across the done cycle.
        @(negedge clk);
        d    = 8'h01;
        v[0] = 1'b1;
        wait_ready(0);
        ta = cyc;
        @(negedge clk);
        d = 8'h02;
        wait_done(0);
        check("b2b first done latency", cyc - ta, 161);
        check("b2b ready in done cycle", rdy[0], 1);
        ta2 = cyc;
        @(negedge clk);
        v[0] = 1'b0;
        check("b2b second start pulse", ir[0], 1);
        check("b2b second busy", bsy[0], 1);
        wait_done(0);
        check("b2b second done latency", cyc - ta2, 161);

        // ena low for 5 cycles while inside the start-bit pulse.
        @(negedge clk);
        d    = 8'h00;
        v[0] = 1'b1;
        wait_ready(0);
        ta = cyc;
        @(negedge clk);
        v[0] = 1'b0;
        @(negedge clk);
        ena      = 1'b0;
        hold_err = 0;
        repeat (5) begin
            @(negedge clk);
            if (ir[0] !== 1'b1 || rdy[0] !== 1'b0 || dn[0] !== 1'b0) hold_err++;
        end
        ena = 1'b1;
        check("ena hold errors", hold_err, 0);
        wait_done(0);
        check("ena shifted done latency", cyc - ta, 166);

        // Reset during data bit 3 (bit period 4).
        @(negedge clk);
        d    = 8'h00;
        v[0] = 1'b1;
        wait_ready(0);
        ta = cyc;
        @(negedge clk);
        v[0] = 1'b0;
        repeat (65) @(negedge clk);
        check("pre-abort pulse", ir[0], 1);
        rst = 1'b0;
        #1;
        check("abort txd_ir", ir[0], 0);
        check("abort busy", bsy[0], 0);
        check("abort ready", rdy[0], 0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            done_cnt += int'(dn[0]);
        end
        rst = 1'b1;
        #1;
        check("ready after abort release", rdy[0], 1);
        repeat (150) begin
            @(negedge clk);
            done_cnt += int'(dn[0]);
        end
        check("abort no done", done_cnt, 0);
        run_frame(0, 8'h55, 13'h155, "post-abort 55");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
